// File: rtl/systolic_ctrl.sv
// -----------------------------------------------------------------------------
// systolic_ctrl
//
// Controller for a 4x4 output-stationary systolic multiply array. It takes one
// pair of 4x4 8-bit matrices (A, B) and runs the array through five phases:
//   1. clear the array accumulators;
//   2. stream both matrices in skewed form over seven cycles;
//   3. wait FLUSH_CYCLES cycles for the last partial products to settle;
//   4. register the 16-bit accumulators as the product C = A*B;
//   5. hold C until the consumer takes it.
// Arithmetic is unsigned 8x8 with 16-bit accumulation inside the array.
// Overflow wraps and is not flagged.
//
// Optional feature:
//   `define SYSTOLIC_CTRL_PERF_CNT_EN adds a 16-bit output o_opCount. It counts
//   completed result handshakes and wraps from 0xFFFF to 0.
//
// Parameters:
//   FLUSH_CYCLES  idle cycles after the last feed before sampling i_c (4..15)
//
// Ports:
//   i_clk      clock, rising edge
//   i_arst     asynchronous reset, active low
//   i_valid    operand pair offered
//   o_ready    operand pair can be accepted (IDLE only)
//   i_a        matrix A, element [row][k]
//   i_b        matrix B, element [k][col]
//   o_peClr    one-cycle clear pulse to the array accumulators
//   o_row      skewed A feed; [i][0] drives array row i now, [i][k] is the
//              value row i will carry k cycles later
//   o_col      skewed B feed, same look-ahead layout as o_row
//   i_c        array accumulator outputs
//   o_c        registered product
//   o_cValid   o_c holds a completed product
//   i_cReady   consumer accepts o_c
//   o_opCount  (optional) completed-operation counter
// -----------------------------------------------------------------------------
module systolic_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 4
) (
    input  logic                    i_clk,
    input  logic                    i_arst,
    input  logic                    i_valid,
    output logic                    o_ready,
    input  logic [3:0][3:0][7:0]    i_a,
    input  logic [3:0][3:0][7:0]    i_b,
    output logic                    o_peClr,
    output logic [3:0][6:0][7:0]    o_row,
    output logic [3:0][6:0][7:0]    o_col,
    input  logic [3:0][3:0][15:0]   i_c,
    output logic [3:0][3:0][15:0]   o_c,
    output logic                    o_cValid,
    input  logic                    i_cReady
`ifdef SYSTOLIC_CTRL_PERF_CNT_EN
    ,
    output logic [15:0]             o_opCount
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FEED,
        FLUSH,
        DONE
    } state_t;

    // A skewed feed of a 4-wide matrix into a 4x4 array takes 4+4-1 slots.
    localparam logic [2:0] FEED_LAST  = 3'd6;
    localparam logic [3:0] FLUSH_LAST = 4'(FLUSH_CYCLES - 1);

    state_t                   state_q, state_d;
    logic [3:0][3:0][7:0]     a_q, a_d;
    logic [3:0][3:0][7:0]     b_q, b_d;
    logic [2:0]               t_q, t_d;
    logic [3:0]               flush_q, flush_d;
    logic [3:0][3:0][15:0]    c_q, c_d;

    // Value on array row `row` in feed slot `slot`. Row i is delayed by i
    // slots, so slot t carries A[row][t-row]. Slots outside the seven feed
    // slots and out-of-range k positions carry zero. The zeros keep the
    // accumulators from picking up stray products.
    function automatic logic [7:0] feed_a(input logic [3:0][3:0][7:0] m,
                                          input int slot, input int row);
        logic [7:0] val;
        val = '0;
        if (slot <= 6 && slot >= row && slot - row <= 3) begin
            val = m[2'(row)][2'(slot - row)];
        end
        return val;
    endfunction

    // Column counterpart of feed_a. Column j carries B[t-j][j].
    function automatic logic [7:0] feed_b(input logic [3:0][3:0][7:0] m,
                                          input int slot, input int col);
        logic [7:0] val;
        val = '0;
        if (slot <= 6 && slot >= col && slot - col <= 3) begin
            val = m[2'(slot - col)][2'(col)];
        end
        return val;
    endfunction

    // Next-state logic. Operands are captured only on the IDLE accept.
    // The product register only loads on the last flush cycle, so o_c stays
    // put for the whole of DONE however long the consumer stalls.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        t_d     = t_q;
        flush_d = flush_q;
        c_d     = c_q;
        case (state_q)
            IDLE: begin
                if (i_valid) begin
                    a_d     = i_a;
                    b_d     = i_b;
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                t_d     = '0;
                state_d = FEED;
            end
            FEED: begin
                if (t_q == FEED_LAST) begin
                    t_d     = '0;
                    flush_d = '0;
                    state_d = FLUSH;
                end else begin
                    t_d = t_q + 3'd1;
                end
            end
            FLUSH: begin
                if (flush_q == FLUSH_LAST) begin
                    flush_d = '0;
                    c_d     = i_c;
                    state_d = DONE;
                end else begin
                    flush_d = flush_q + 4'd1;
                end
            end
            DONE: begin
                if (i_cReady) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_arst) begin
        if (!i_arst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            t_q     <= '0;
            flush_q <= '0;
            c_q     <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            t_q     <= t_d;
            flush_q <= flush_d;
            c_q     <= c_d;
        end
    end

    // Feed outputs are decoded from registered state only. Reset therefore
    // zeroes them at once, without waiting for a clock edge. Look-ahead
    // element k shows feed slot t+k. It reads zero once t+k runs past the
    // last feed slot.
    always_comb begin
        o_row = '0;
        o_col = '0;
        if (state_q == FEED) begin
            for (int i = 0; i < 4; i++) begin
                for (int k = 0; k < 7; k++) begin
                    o_row[i][k] = feed_a(a_q, int'(t_q) + k, i);
                    o_col[i][k] = feed_b(b_q, int'(t_q) + k, i);
                end
            end
        end
    end

    assign o_ready  = (state_q == IDLE);
    assign o_peClr  = (state_q == CLEAR);
    assign o_cValid = (state_q == DONE);
    assign o_c      = c_q;

`ifdef SYSTOLIC_CTRL_PERF_CNT_EN
    logic [15:0] op_count_q, op_count_d;

    // Count result handshakes. The 16-bit add wraps naturally.
    always_comb begin
        op_count_d = op_count_q;
        if (state_q == DONE && i_cReady) begin
            op_count_d = op_count_q + 16'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_arst) begin
        if (!i_arst) begin
            op_count_q <= '0;
        end else begin
            op_count_q <= op_count_d;
        end
    end

    assign o_opCount = op_count_q;
`endif

endmodule
